// File: rtl/mem_stage_pkg.sv
// Shared RV32I instruction/funct3 types and pipeline control types for the MEM stage.
// rv32i_types holds ISA-level encodings; ctrl_types holds pipeline control word and FSM states.
package rv32i_types;
    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;
endpackage

package ctrl_types;
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;
endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane formatting: store data/byte enables and load extraction/extension.
// Purely combinational; misaligned offsets are truncated to the access size.
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  rv32i_word   store_data_i,
    input  rv32i_word   load_raw_i,
    output logic [3:0]  store_mbe_o,
    output rv32i_word   store_wdata_o,
    output rv32i_word   load_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = load_raw_i[{offset_i, 3'b000} +: 8];
        ld_half = load_raw_i[{offset_i[1], 4'b0000} +: 16];
    end

    always_comb begin
        store_mbe_o   = 4'b1111;
        store_wdata_o = store_data_i;
        case (funct3_i)
            sb: begin
                store_mbe_o   = 4'b0001 << offset_i;
                store_wdata_o = {4{store_data_i[7:0]}};
            end
            sh: begin
                store_mbe_o   = 4'b0011 << {offset_i[1], 1'b0};
                store_wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                store_mbe_o   = 4'b1111;
                store_wdata_o = store_data_i;
            end
        endcase
    end

    always_comb begin
        load_data_o = load_raw_i;
        case (funct3_i)
            lb:      load_data_o = {{24{ld_byte[7]}}, ld_byte};
            lbu:     load_data_o = {24'h000000, ld_byte};
            lh:      load_data_o = {{16{ld_half[15]}}, ld_half};
            lhu:     load_data_o = {16'h0000, ld_half};
            default: load_data_o = load_raw_i;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream until dmem_resp, fills MEM/WB.
// Zero-stall when the response arrives in the issue cycle; bubbles MEM/WB while stalled.
module mem_stage
    import rv32i_types::*;
    import ctrl_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  instr_t      exmem_instruction,
    input  ctrl_t       exmem_ctrl_word,
    input  logic        exmem_valid,
    input  rv32i_word   exmem_alu_out,
    input  rv32i_word   exmem_rs2_out,
    input  rv32i_word   exmem_pc,
    input  logic        exmem_br_en,
    output logic        dmem_read,
    output logic        dmem_write,
    output rv32i_word   dmem_address,
    output rv32i_word   dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  rv32i_word   dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output instr_t      memwb_instruction,
    output ctrl_t       memwb_ctrl_word,
    output rv32i_word   memwb_alu_out,
    output logic        memwb_br_en,
    output rv32i_word   memwb_rdata,
    output rv32i_word   memwb_pc,
    output logic        memwb_valid
);
    mem_state_t  state_q, state_d;
    logic        req_rd_q, req_wr_q;
    rv32i_word   req_addr_q, req_wdata_q;
    logic [3:0]  req_mbe_q;

    logic        mem_op, new_rd, new_wr;
    logic [3:0]  align_mbe;
    rv32i_word   align_wdata, load_data;

    mem_align u_align (
        .funct3_i      (exmem_instruction.funct3),
        .offset_i      (exmem_alu_out[1:0]),
        .store_data_i  (exmem_rs2_out),
        .load_raw_i    (dmem_rdata),
        .store_mbe_o   (align_mbe),
        .store_wdata_o (align_wdata),
        .load_data_o   (load_data)
    );

    assign mem_op = exmem_valid & (exmem_ctrl_word.mem_read | exmem_ctrl_word.mem_write);
    assign new_rd = mem_op & exmem_ctrl_word.mem_read;
    assign new_wr = mem_op & exmem_ctrl_word.mem_write;
    assign mem_stall = ~rst & mem_op & ~dmem_resp;

    // While BUSY the bus is driven from the captured request so it cannot wobble.
    always_comb begin
        dmem_read    = new_rd;
        dmem_write   = new_wr;
        dmem_address = {exmem_alu_out[31:2], 2'b00};
        dmem_wdata   = align_wdata;
        dmem_mbe     = new_wr ? align_mbe : 4'b0000;
        if (state_q == BUSY) begin
            dmem_read    = req_rd_q;
            dmem_write   = req_wr_q;
            dmem_address = req_addr_q;
            dmem_wdata   = req_wdata_q;
            dmem_mbe     = req_mbe_q;
        end
        if (rst) begin
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_op && !dmem_resp) state_d = BUSY;
            BUSY:    if (dmem_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_mbe_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == BUSY) begin
                req_rd_q    <= dmem_read;
                req_wr_q    <= dmem_write;
                req_addr_q  <= dmem_address;
                req_wdata_q <= dmem_wdata;
                req_mbe_q   <= dmem_mbe;
            end
        end
    end

    // A stalled slot becomes an all-zero bubble so writeback commits each instruction once.
    always_ff @(posedge clk) begin
        if (rst || mem_stall) begin
            memwb_instruction <= '0;
            memwb_ctrl_word   <= '0;
            memwb_alu_out     <= '0;
            memwb_br_en       <= 1'b0;
            memwb_rdata       <= '0;
            memwb_pc          <= '0;
            memwb_valid       <= 1'b0;
        end else begin
            memwb_instruction <= exmem_instruction;
            memwb_ctrl_word   <= exmem_ctrl_word;
            memwb_alu_out     <= exmem_alu_out;
            memwb_br_en       <= exmem_br_en;
            memwb_rdata       <= new_rd ? load_data : '0;
            memwb_pc          <= exmem_pc;
            memwb_valid       <= exmem_valid;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB records queued at issue, popped on memwb_valid.
module tb_mem_stage;
    import rv32i_types::*;
    import ctrl_types::*;

    logic        clk, rst;
    instr_t      exmem_instruction;
    ctrl_t       exmem_ctrl_word;
    logic        exmem_valid, exmem_br_en;
    rv32i_word   exmem_alu_out, exmem_rs2_out, exmem_pc;
    logic        dmem_read, dmem_write;
    rv32i_word   dmem_address, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_mbe;
    logic        dmem_resp, mem_stall;
    instr_t      memwb_instruction;
    ctrl_t       memwb_ctrl_word;
    rv32i_word   memwb_alu_out, memwb_rdata, memwb_pc;
    logic        memwb_br_en, memwb_valid;

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .exmem_instruction (exmem_instruction),
        .exmem_ctrl_word   (exmem_ctrl_word),
        .exmem_valid       (exmem_valid),
        .exmem_alu_out     (exmem_alu_out),
        .exmem_rs2_out     (exmem_rs2_out),
        .exmem_pc          (exmem_pc),
        .exmem_br_en       (exmem_br_en),
        .dmem_read         (dmem_read),
        .dmem_write        (dmem_write),
        .dmem_address      (dmem_address),
        .dmem_wdata        (dmem_wdata),
        .dmem_mbe          (dmem_mbe),
        .dmem_rdata        (dmem_rdata),
        .dmem_resp         (dmem_resp),
        .mem_stall         (mem_stall),
        .memwb_instruction (memwb_instruction),
        .memwb_ctrl_word   (memwb_ctrl_word),
        .memwb_alu_out     (memwb_alu_out),
        .memwb_br_en       (memwb_br_en),
        .memwb_rdata       (memwb_rdata),
        .memwb_pc          (memwb_pc),
        .memwb_valid       (memwb_valid)
    );

    typedef struct {
        rv32i_word pc;
        rv32i_word alu;
        rv32i_word rdata;
        instr_t    instr;
        logic      br_en;
        logic      load_rf;
    } exp_t;

    exp_t scb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk_instr(input logic [6:0] opc, input logic [2:0] f3);
        instr_t i;
        i        = '0;
        i.opcode = opc;
        i.funct3 = f3;
        i.rd     = 5'd3;
        i.rs1    = 5'd1;
        i.rs2    = 5'd2;
        return i;
    endfunction

    always @(negedge clk) begin
        if (!rst && memwb_valid) begin
            if (scb_q.size() == 0) begin
                chk("unexpected_valid", {31'd0, memwb_valid}, 32'd0);
            end else begin
                exp_t e;
                e = scb_q.pop_front();
                chk("wb_pc",     memwb_pc, e.pc);
                chk("wb_alu",    memwb_alu_out, e.alu);
                chk("wb_rdata",  memwb_rdata, e.rdata);
                chk("wb_instr",  memwb_instruction, e.instr);
                chk("wb_br_en",  {31'd0, memwb_br_en}, {31'd0, e.br_en});
                chk("wb_ld_rf",  {31'd0, memwb_ctrl_word.load_regfile}, {31'd0, e.load_rf});
            end
        end
    end

    // Drives one EX/MEM instruction, answers after 'delay' cycles, checks the bus each cycle.
    task automatic issue(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic rd, input logic wr, input rv32i_word a, input rv32i_word rs2,
                         input rv32i_word pc, input rv32i_word rdata, input int delay,
                         input rv32i_word exp_addr, input logic [3:0] exp_mbe,
                         input rv32i_word exp_wdata, input rv32i_word exp_rd);
        exp_t e;
        logic memop;
        int   last;
        memop = rd | wr;
        exmem_instruction            = mk_instr(opc, f3);
        exmem_ctrl_word              = '0;
        exmem_ctrl_word.aluop        = 3'd2;
        exmem_ctrl_word.load_regfile = ~wr;
        exmem_ctrl_word.mem_read     = rd;
        exmem_ctrl_word.mem_write    = wr;
        exmem_valid   = 1'b1;
        exmem_alu_out = a;
        exmem_rs2_out = rs2;
        exmem_pc      = pc;
        exmem_br_en   = pc[2];
        dmem_rdata    = rdata;
        e.pc = pc; e.alu = a; e.rdata = exp_rd; e.instr = exmem_instruction;
        e.br_en = pc[2]; e.load_rf = ~wr;
        scb_q.push_back(e);
        last = memop ? delay : 0;
        for (int c = 0; c <= last; c++) begin
            dmem_resp = memop && (c == delay);
            #2;
            chk({tag, "_stall"}, {31'd0, mem_stall}, {31'd0, (memop && c < delay)});
            chk({tag, "_rd"}, {31'd0, dmem_read}, {31'd0, rd});
            chk({tag, "_wr"}, {31'd0, dmem_write}, {31'd0, wr});
            if (memop) chk({tag, "_addr"}, dmem_address, exp_addr);
            if (wr || !memop) chk({tag, "_mbe"}, {28'd0, dmem_mbe}, {28'd0, exp_mbe});
            if (wr) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
            if (c > 0) begin
                chk({tag, "_bubble_vld"}, {31'd0, memwb_valid}, 32'd0);
                chk({tag, "_bubble_ldrf"}, {31'd0, memwb_ctrl_word.load_regfile}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        exmem_valid = 1'b0;
        dmem_resp   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        exmem_instruction = mk_instr(OPC_LOAD, lw);
        exmem_ctrl_word   = '0;
        exmem_ctrl_word.mem_read = 1'b1;
        exmem_valid = 1'b1;
        exmem_alu_out = 32'h0000_0100;
        exmem_rs2_out = '0;
        exmem_pc = '0;
        exmem_br_en = 1'b0;
        dmem_rdata = '0;
        dmem_resp = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_dmem_read", {31'd0, dmem_read}, 32'd0);
        chk("rst_dmem_write", {31'd0, dmem_write}, 32'd0);
        chk("rst_wb_valid", {31'd0, memwb_valid}, 32'd0);
        chk("rst_wb_rdata", memwb_rdata, 32'd0);
        chk("rst_wb_pc", memwb_pc, 32'd0);
        chk("rst_wb_alu", memwb_alu_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exmem_valid = 1'b0;
        @(posedge clk);
        #1;

        issue("lw",  OPC_LOAD,  lw,  1, 0, 32'h100, 32'h0, 32'h1000, 32'hDEADBEEF, 3,
              32'h100, 4'b0000, 32'h0, 32'hDEADBEEF);
        issue("lb",  OPC_LOAD,  lb,  1, 0, 32'h103, 32'h0, 32'h1004, 32'h80FFFFFF, 1,
              32'h100, 4'b0000, 32'h0, 32'hFFFFFF80);
        issue("lbu", OPC_LOAD,  lbu, 1, 0, 32'h103, 32'h0, 32'h1008, 32'h80FFFFFF, 2,
              32'h100, 4'b0000, 32'h0, 32'h00000080);
        issue("lhu", OPC_LOAD,  lhu, 1, 0, 32'h102, 32'h0, 32'h100C, 32'h80011234, 0,
              32'h100, 4'b0000, 32'h0, 32'h00008001);
        issue("lh",  OPC_LOAD,  lh,  1, 0, 32'h100, 32'h0, 32'h1010, 32'h00009ABC, 1,
              32'h100, 4'b0000, 32'h0, 32'hFFFF9ABC);
        issue("sh",  OPC_STORE, sh,  0, 1, 32'h206, 32'h1234ABCD, 32'h1014, 32'hFFFFFFFF, 2,
              32'h204, 4'b1100, 32'hABCDABCD, 32'h0);
        issue("sb",  OPC_STORE, sb,  0, 1, 32'h301, 32'h00000055, 32'h1018, 32'h0, 0,
              32'h300, 4'b0010, 32'h55555555, 32'h0);
        issue("sw",  OPC_STORE, sw,  0, 1, 32'h040, 32'hCAFEF00D, 32'h101C, 32'h0, 1,
              32'h040, 4'b1111, 32'hCAFEF00D, 32'h0);
        issue("add", OPC_OP,    3'b000, 0, 0, 32'h77, 32'h5, 32'h1020, 32'h0, 0,
              32'h0, 4'b0000, 32'h0, 32'h0);
        issue("lw2", OPC_LOAD,  lw,  1, 0, 32'h104, 32'h0, 32'h1024, 32'h13572468, 2,
              32'h104, 4'b0000, 32'h0, 32'h13572468);
        issue("lwmis", OPC_LOAD, lw, 1, 0, 32'h10A, 32'h0, 32'h1028, 32'h0BADF00D, 1,
              32'h108, 4'b0000, 32'h0, 32'h0BADF00D);

        // Load left hanging, then reset while BUSY followed by a stray response.
        exmem_instruction = mk_instr(OPC_LOAD, lw);
        exmem_ctrl_word = '0;
        exmem_ctrl_word.load_regfile = 1'b1;
        exmem_ctrl_word.mem_read = 1'b1;
        exmem_valid = 1'b1;
        exmem_alu_out = 32'h500;
        exmem_pc = 32'h2000;
        dmem_resp = 1'b0;
        repeat (2) begin
            #2;
            chk("busy_stall", {31'd0, mem_stall}, 32'd1);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #2;
        chk("rstbusy_rd", {31'd0, dmem_read}, 32'd0);
        chk("rstbusy_wr", {31'd0, dmem_write}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exmem_valid = 1'b0;
        dmem_resp = 1'b1;
        #2;
        chk("stray_stall", {31'd0, mem_stall}, 32'd0);
        chk("stray_rd", {31'd0, dmem_read}, 32'd0);
        chk("stray_wb_vld", {31'd0, memwb_valid}, 32'd0);
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        #2;
        chk("stray_no_capture", {31'd0, memwb_valid}, 32'd0);
        @(posedge clk);
        #1;

        issue("add2", OPC_OP, 3'b000, 0, 0, 32'h99, 32'h1, 32'h2004, 32'h0, 0,
              32'h0, 4'b0000, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        chk("scb_drain", scb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
